// File: rtl/adc_128s.sv
// SPI slave model of an 8-channel 12-bit ADC with a pipelined channel read.
// Optional macro ADC128S_RAMP_EN makes each channel step by 12'h010 per completed read.
module adc_128s #(
    parameter logic [11:0] CH0_VAL = 12'h800,
    parameter logic [11:0] CH1_VAL = 12'h000,
    parameter logic [11:0] CH2_VAL = 12'h000,
    parameter logic [11:0] CH3_VAL = 12'h000,
    parameter logic [11:0] CH4_VAL = 12'h000,
    parameter logic [11:0] CH5_VAL = 12'h000,
    parameter logic [11:0] CH6_VAL = 12'h000,
    parameter logic [11:0] CH7_VAL = 12'h800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);

    localparam logic [11:0] CH_INIT [8] = '{CH0_VAL, CH1_VAL, CH2_VAL, CH3_VAL,
                                            CH4_VAL, CH5_VAL, CH6_VAL, CH7_VAL};

    logic [1:0]  ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic        ss_prev_q, sclk_prev_q;
    logic [15:0] tx_q, rx_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [2:0]  chan_q;
    logic        active_q;
    logic [11:0] result;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, in_frame, sclk_rise, sclk_fall, frame_done;

    assign ss_s   = ss_sync_q[1];
    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    // active_q is only set on the cycle after a frame start, so an SCLK edge
    // coincident with the SS_n fall is dropped in favour of the frame start.
    assign ss_fall    = ss_prev_q & ~ss_s;
    assign ss_rise    = ~ss_prev_q & ss_s;
    assign in_frame   = active_q & ~ss_s;
    assign sclk_rise  = in_frame & ~sclk_prev_q & sclk_s;
    assign sclk_fall  = in_frame & sclk_prev_q & ~sclk_s;
    assign frame_done = ss_rise & (cnt_q == 5'd16);
    assign cnt_d      = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;

`ifdef ADC128S_RAMP_EN
    logic [11:0] val_q [8];

    assign result = val_q[chan_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) val_q[i] <= CH_INIT[i];
        end else if (frame_done) begin
            val_q[chan_q] <= val_q[chan_q] + 12'h010;
        end
    end
`else
    assign result = CH_INIT[chan_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b11;
            mosi_sync_q <= 2'b00;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            chan_q      <= '0;
            active_q    <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[0], SS_n};
            sclk_sync_q <= {sclk_sync_q[0], SCLK};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
            if (ss_fall) begin
                cnt_q    <= '0;
                tx_q     <= {4'b0000, result};
                active_q <= 1'b1;
            end else if (ss_rise) begin
                active_q <= 1'b0;
                if (frame_done) chan_q <= rx_q[13:11];
            end else begin
                if (sclk_rise) begin
                    rx_q  <= {rx_q[14:0], mosi_s};
                    cnt_q <= cnt_d;
                end
                // Zero fill means MISO reads 0 once all 16 bits are out.
                if (sclk_fall) tx_q <= {tx_q[14:0], 1'b0};
            end
        end
    end

    assign MISO = active_q ? tx_q[15] : 1'bz;

    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx_q[15:14], rx_q[10:0]};

endmodule

// File: tb/tb_adc_128s.sv
// Bench for adc_128s (default build): table of channel reads checked through a
// scoreboard, plus short/long/idle-clock/mid-frame-reset sequences.
module tb_adc_128s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n = 1'b1;
    logic sclk = 1'b1;
    logic mosi = 1'b0;
    wire  miso;

    pullup (miso);

    adc_128s dut (
        .clk  (clk),
        .rst_n(rst_n),
        .SS_n (ss_n),
        .SCLK (sclk),
        .MOSI (mosi),
        .MISO (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q [$];

    typedef struct {
        logic [2:0]  add;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] cmd_word(input logic [2:0] add);
        return {2'b00, add, 11'b0};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // MISO is sampled while SCLK is high, just before each falling edge.
    task automatic sclk_bits(input logic [15:0] cmd, input int nclk, inout logic [63:0] rd);
        for (int i = 0; i < nclk; i++) begin
            rd   = {rd[62:0], miso};
            mosi = cmd[4'(15 - (i % 16))];
            sclk = 1'b0;
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(6);
        end
    endtask

    task automatic frame(input logic [15:0] cmd, input int nclk, output logic [63:0] rd);
        rd   = '0;
        ss_n = 1'b0;
        wait_clk(8);
        sclk_bits(cmd, nclk, rd);
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic run_full(input logic [2:0] add, input string name);
        logic [63:0] rd;
        logic [15:0] exp;
        frame(cmd_word(add), 16, rd);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got frame expected scoreboard entry", name);
        end else begin
            exp = sb_q.pop_front();
            check(name, {48'h0, rd[15:0]}, {48'h0, exp});
        end
    endtask

    initial begin
        logic [63:0] rd;

        vecs[0] = '{3'd0, 16'h0800};
        vecs[1] = '{3'd7, 16'h0800};
        vecs[2] = '{3'd4, 16'h0800};
        vecs[3] = '{3'd0, 16'h0000};
        vecs[4] = '{3'd3, 16'h0800};
        vecs[5] = '{3'd1, 16'h0000};
        vecs[6] = '{3'd7, 16'h0000};
        vecs[7] = '{3'd7, 16'h0800};

        wait_clk(3);
        check("reset_hiz", {63'h0, miso}, 64'h1);
        rst_n = 1'b1;
        wait_clk(4);
        check("idle_after_reset", {63'h0, miso}, 64'h1);

        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].exp);
            run_full(vecs[i].add, $sformatf("vec%0d", i));
        end

        // Short frame carrying ADD=5 must leave the pointer at 7.
        frame(cmd_word(3'd5), 9, rd);
        sb_q.push_back(16'h0800);
        run_full(3'd4, "after_short");

        // SCLK activity with SS_n high must be ignored.
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            sclk = 1'b0;
            wait_clk(6);
            sclk = 1'b1;
            wait_clk(6);
        end
        check("idle_sclk_hiz", {63'h0, miso}, 64'h1);
        mosi = 1'b0;
        sb_q.push_back(16'h0000);
        run_full(3'd4, "after_idle_sclk");

        // Reset in the middle of a frame.
        rd   = '0;
        ss_n = 1'b0;
        wait_clk(8);
        sclk_bits(cmd_word(3'd6), 5, rd);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hiz", {63'h0, miso}, 64'h1);
        ss_n = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        sb_q.push_back(16'h0800);
        run_full(3'd7, "after_rst");

        // 48-clock frame: counter must saturate, MISO zero after 16 bits.
        frame(cmd_word(3'd4), 48, rd);
        check("long_data", {16'h0, rd[47:0]}, {16'h0, 16'h0800, 32'h0});
        sb_q.push_back(16'h0800);
        run_full(3'd0, "after_long");

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left got %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
